// File: rtl/scan_dtype.sv
// Scan-enabled D-type flip-flop: 2:1 mux (D or SDI under Test) into a
// rising-edge register with asynchronous active-low reset and complementary outputs.
module scan_dtype (
    input  logic Clock,
    input  logic nReset,
    input  logic D,
    input  logic SDI,
    input  logic Test,
    output logic Q,
    output logic nQ
);
    timeunit 1ns;
    timeprecision 10ps;

    logic next;

    always_comb begin
        next = D;
        if (Test) begin
            next = SDI;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Q <= 1'b0;
        end else begin
            Q <= next;
        end
    end

    // Derived from Q so the pair can never disagree, including during reset.
    assign nQ = ~Q;

endmodule

// File: tb/tb_scan_dtype.sv
// Directed-vector bench for scan_dtype on the 1000 ns reference clock
// (rising edges at 250 + 1000k ns).
module tb_scan_dtype;
    timeunit 1ns;
    timeprecision 10ps;

    logic Clock;
    logic nReset;
    logic D;
    logic SDI;
    logic Test;
    logic Q;
    logic nQ;

    int unsigned n_tests;
    int unsigned n_fail;

    scan_dtype dut (
        .Clock  (Clock),
        .nReset (nReset),
        .D      (D),
        .SDI    (SDI),
        .Test   (Test),
        .Q      (Q),
        .nQ     (nQ)
    );

    initial begin
        Clock = 1'b0;
        forever begin
            #250 Clock = 1'b1;
            #500 Clock = 1'b0;
            #250;
        end
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t ns: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic exp);
        check({tag, "_q"}, Q, exp);
        check({tag, "_nq"}, nQ, ~exp);
    endtask

    task automatic at(input int unsigned t);
        if (t > $time) begin
            #(t - $time);
        end
    endtask

    // Outputs may only move at a rising edge or while reset is asserted.
    always @(Q or nQ) begin
        if ($time > 0) begin
            check("change_time", ((Clock === 1'b1) && (($time % 1000) == 250)) || (nReset === 1'b0), 1'b1);
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nReset = 1'b0;
        D      = 1'b0;
        SDI    = 1'b0;
        Test   = 1'b0;

        at(100);   check_q("reset_state", 1'b0);
        at(260);   check_q("reset_hold_edge", 1'b0);
        at(1000);  nReset = 1'b1;
        at(1010);  check_q("release_no_change", 1'b0);
        at(1260);  check_q("first_edge_d0", 1'b0);
        at(2000);  D = 1'b1;
        at(2100);  check_q("no_change_between_edges", 1'b0);
        at(2260);  check_q("func_d1", 1'b1);
        at(3000);  Test = 1'b1; SDI = 1'b0; D = 1'b1;
        at(3100);  check_q("test_switch_no_change", 1'b1);
        at(3260);  check_q("scan_sdi0", 1'b0);
        at(4000);  SDI = 1'b1; D = 1'b0;
        at(4260);  check_q("scan_sdi1_d_ignored", 1'b1);
        at(4500);  nReset = 1'b0;
        at(4510);  check_q("async_reset_mid_cycle", 1'b0);
        at(4600);  nReset = 1'b1;
        at(4610);  check_q("async_release_no_change", 1'b0);
        at(4760);  check_q("falling_edge_after_release", 1'b0);
        at(5000);  Test = 1'b0; D = 1'b0; SDI = 1'b1;
        at(5260);  check_q("func_return_d0", 1'b0);
        at(6000);  D = 1'b1;
        at(6260);  check_q("reload_d1", 1'b1);
        at(6500);  D = 1'b0;
        at(6760);  check_q("falling_edge_no_effect", 1'b1);
        at(7000);  nReset = 1'b0; D = 1'b1;
        at(7010);  check_q("reset_assert_low", 1'b0);
        at(7260);  check_q("reset_blocks_edge_d1", 1'b0);
        at(7900);  nReset = 1'b1;
        at(8260);  check_q("reload_after_reset", 1'b1);
        at(9000);  Test = 1'b1; SDI = 1'b0; D = 1'b1;
        at(9260);  check_q("scan_d_ignored", 1'b0);
        at(10000); Test = 1'b0; D = 1'b1;
        at(10250); nReset = 1'b0;
        at(10260); check_q("reset_wins_at_edge", 1'b0);
        at(10500); nReset = 1'b1;
        at(11260); check_q("final_capture", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
